// File: rtl/etc_block_fetcher.sv
// rtl/etc_block_fetcher.sv - ETC2 compressed block fetcher walking an image in raster block order
//
// Purpose: for an image of width x height pixels (4x4 pixel ETC2 blocks, 8 bytes each,
// stored contiguously in raster order from src_base) read every block as two 32-bit
// words and present it downstream together with its block coordinates.
//
// Ports:
//   sclk, rsrt                      clock (rising edge), asynchronous active-high reset
//   start, src_base, width, height  job launch; parameters sampled when start is accepted in IDLE
//   rd_req, rd_addr, rd_gnt         read request handshake, one read outstanding at a time
//   rd_dvalid, rd_data              read return
//   blk_valid, blk_rtr              block output handshake
//   blk_data, blk_x, blk_y          block payload ([63:32] = word at block address) and coordinates
//   busy, done                      job in progress / one-cycle completion pulse
//
// Build option: ETC_FETCH_BSWAP_EN - byte-reverse each returned word before storing it.

module etc_block_fetcher (
  input  logic        sclk,
  input  logic        rsrt,
  input  logic        start,
  input  logic [31:0] src_base,
  input  logic [10:0] width,
  input  logic [10:0] height,
  output logic        rd_req,
  output logic [31:0] rd_addr,
  input  logic        rd_gnt,
  input  logic        rd_dvalid,
  input  logic [31:0] rd_data,
  output logic        blk_valid,
  input  logic        blk_rtr,
  output logic [63:0] blk_data,
  output logic [7:0]  blk_x,
  output logic [7:0]  blk_y,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ0  = 3'd1,
    S_WAIT0 = 3'd2,
    S_REQ1  = 3'd3,
    S_WAIT1 = 3'd4,
    S_OUT   = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nxt;

  // Byte address of the current block; advanced by 8 per block because the
  // raster walk visits blocks in storage order, so no multiply is needed.
  logic [31:0] blk_addr;
  logic [7:0]  last_x;
  logic [7:0]  last_y;

  logic [8:0]  bpr;
  logic [8:0]  bpc;
  logic        accept;
  logic        xfer;
  logic        last_blk;
  logic [31:0] rd_word;
  logic        unused_lsbs;

  assign bpr         = width[10:2];
  assign bpc         = height[10:2];
  // Pixel dimensions are multiples of 4, so the two low bits carry no information.
  assign unused_lsbs = ^{width[1:0], height[1:0]};

  assign accept   = (state == S_IDLE) && start;
  assign xfer     = (state == S_OUT) && blk_rtr;
  assign last_blk = (blk_x == last_x) && (blk_y == last_y);

`ifdef ETC_FETCH_BSWAP_EN
  assign rd_word = {rd_data[7:0], rd_data[15:8], rd_data[23:16], rd_data[31:24]};
`else
  assign rd_word = rd_data;
`endif

  // State register
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_nxt = state;
    rd_req    = 1'b0;
    rd_addr   = 32'd0;
    blk_valid = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = S_REQ0;
        end
      end
      S_REQ0: begin
        rd_req  = 1'b1;
        rd_addr = blk_addr;
        if (rd_gnt) begin
          state_nxt = S_WAIT0;
        end
      end
      S_WAIT0: begin
        if (rd_dvalid) begin
          state_nxt = S_REQ1;
        end
      end
      S_REQ1: begin
        rd_req  = 1'b1;
        rd_addr = blk_addr + 32'd4;
        if (rd_gnt) begin
          state_nxt = S_WAIT1;
        end
      end
      S_WAIT1: begin
        if (rd_dvalid) begin
          state_nxt = S_OUT;
        end
      end
      S_OUT: begin
        blk_valid = 1'b1;
        if (blk_rtr) begin
          state_nxt = last_blk ? S_DONE : S_REQ0;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Job parameters, block position and captured block data
  always_ff @(posedge sclk or posedge rsrt) begin
    if (rsrt) begin
      blk_addr <= 32'd0;
      last_x   <= 8'd0;
      last_y   <= 8'd0;
      blk_x    <= 8'd0;
      blk_y    <= 8'd0;
      blk_data <= 64'd0;
    end else begin
      if (accept) begin
        blk_addr <= src_base;
        last_x   <= 8'(bpr - 9'd1);
        last_y   <= 8'(bpc - 9'd1);
        blk_x    <= 8'd0;
        blk_y    <= 8'd0;
      end
      if ((state == S_WAIT0) && rd_dvalid) begin
        blk_data[63:32] <= rd_word;
      end
      if ((state == S_WAIT1) && rd_dvalid) begin
        blk_data[31:0] <= rd_word;
      end
      // Coordinates of the final block are left in place so they remain
      // visible after done; the next accepted start clears them.
      if (xfer && !last_blk) begin
        blk_addr <= blk_addr + 32'd8;
        if (blk_x == last_x) begin
          blk_x <= 8'd0;
          blk_y <= blk_y + 8'd1;
        end else begin
          blk_x <= blk_x + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_etc_block_fetcher.sv
// tb/tb_etc_block_fetcher.sv - scoreboard bench for etc_block_fetcher with a randomized memory model
module tb_etc_block_fetcher;

  logic        sclk = 1'b0;
  logic        rsrt = 1'b1;
  logic        start = 1'b0;
  logic [31:0] src_base = 32'd0;
  logic [10:0] width = 11'd0;
  logic [10:0] height = 11'd0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_gnt = 1'b0;
  logic        rd_dvalid = 1'b0;
  logic [31:0] rd_data = 32'd0;
  logic        blk_valid;
  logic        blk_rtr = 1'b0;
  logic [63:0] blk_data;
  logic [7:0]  blk_x;
  logic [7:0]  blk_y;
  logic        busy;
  logic        done;

  etc_block_fetcher dut (
    .sclk(sclk), .rsrt(rsrt), .start(start), .src_base(src_base),
    .width(width), .height(height), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_gnt(rd_gnt), .rd_dvalid(rd_dvalid), .rd_data(rd_data),
    .blk_valid(blk_valid), .blk_rtr(blk_rtr), .blk_data(blk_data),
    .blk_x(blk_x), .blk_y(blk_y), .busy(busy), .done(done)
  );

  always #5 sclk = ~sclk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail(input string name, input string msg);
    n_checks++;
    $display("FAIL %s: %s", name, msg);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [63:0] data;
    logic [7:0]  x;
    logic [7:0]  y;
  } blk_t;

  logic [31:0] exp_req[$];
  blk_t        exp_blk[$];
  int          exp_done = 0;
  int          seen_done = 0;

  bit          const_data = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (const_data) return 32'h11223344;
    return (a * 32'h9E3779B1) ^ 32'hC3A55A3C;
  endfunction

  function automatic logic [31:0] stored(input logic [31:0] w);
`ifdef ETC_FETCH_BSWAP_EN
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    return w;
`endif
  endfunction

  task automatic push_job(input logic [31:0] base, input int w, input int h);
    int   bpr;
    int   bpc;
    blk_t b;
    logic [31:0] a;
    bpr = w / 4;
    bpc = h / 4;
    for (int y = 0; y < bpc; y++) begin
      for (int x = 0; x < bpr; x++) begin
        a = base + 32'((y * bpr + x) * 8);
        exp_req.push_back(a);
        exp_req.push_back(a + 32'd4);
        b.data = {stored(mem_word(a)), stored(mem_word(a + 32'd4))};
        b.x = 8'(x);
        b.y = 8'(y);
        exp_blk.push_back(b);
      end
    end
    exp_done++;
  endtask

  // ---------------- memory model ----------------
  int          gnt_pct = 100;
  int          lat_max = 0;
  bit          spur_en = 1'b0;
  bit          hold_en = 1'b0;
  logic [31:0] hold_addr = 32'd0;
  bit          pending = 1'b0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_lat = 0;
  bit          acc_now;
  logic [31:0] acc_addr;

  always begin
    @(negedge sclk);
    acc_now  = rd_req && rd_gnt && !rsrt;
    acc_addr = rd_addr;
    @(posedge sclk);
    #1;
    rd_dvalid = 1'b0;
    rd_data   = $urandom;
    if (acc_now) begin
      check("single_outstanding", 64'(pending), 64'd0);
      pending   = 1'b1;
      pend_addr = acc_addr;
      pend_lat  = $urandom_range(lat_max, 0);
    end
    if (pending && !(hold_en && pend_addr == hold_addr)) begin
      if (pend_lat == 0) begin
        rd_dvalid = 1'b1;
        rd_data   = mem_word(pend_addr);
        pending   = 1'b0;
      end else begin
        pend_lat--;
      end
    end else if (!pending && spur_en && $urandom_range(3, 0) == 0) begin
      rd_dvalid = 1'b1;
    end
    rd_gnt = ($urandom_range(99, 0) < gnt_pct);
  end

  // ---------------- downstream ready driver ----------------
  int rtr_force = 1;
  int rtr_pct = 100;

  always begin
    @(posedge sclk);
    #1;
    if (rtr_force >= 0) blk_rtr = (rtr_force != 0);
    else blk_rtr = ($urandom_range(99, 0) < rtr_pct);
  end

  // ---------------- monitor ----------------
  bit          prev_req_stall = 1'b0;
  bit          prev_blk_stall = 1'b0;
  bit          prev_done = 1'b0;
  logic [31:0] prev_addr;
  logic [79:0] prev_blk;
  logic [31:0] last_req_addr = 32'd0;
  logic [79:0] last_blk = '0;
  int          blk_cnt = 0;

  always @(negedge sclk) begin
    if (rsrt) begin
      prev_req_stall = 1'b0;
      prev_blk_stall = 1'b0;
      prev_done      = 1'b0;
    end else begin
      if (prev_req_stall) begin
        check("req_held", 64'(rd_req), 64'd1);
        check("addr_held", 64'(rd_addr), 64'(prev_addr));
      end
      if (prev_blk_stall) begin
        check("blk_valid_held", 64'(blk_valid), 64'd1);
        check("blk_data_held", blk_data, prev_blk[79:16]);
        check("blk_xy_held", 64'({blk_x, blk_y}), 64'(prev_blk[15:0]));
      end
      if (rd_req && blk_valid) fail("req_during_out", "rd_req and blk_valid both high");
      if (done && prev_done) fail("done_pulse", "done high two cycles");
      if (rd_req && rd_gnt) begin
        if (exp_req.size() == 0) begin
          fail("unexpected_req", $sformatf("rd_addr %h with no expected request", rd_addr));
        end else begin
          check("rd_addr", 64'(rd_addr), 64'(exp_req.pop_front()));
        end
        last_req_addr = rd_addr;
      end
      if (blk_valid && blk_rtr) begin
        if (exp_blk.size() == 0) begin
          fail("unexpected_blk", $sformatf("block %h at (%0d,%0d)", blk_data, blk_x, blk_y));
        end else begin
          blk_t e;
          e = exp_blk.pop_front();
          check("blk_data", blk_data, e.data);
          check("blk_xy", 64'({blk_x, blk_y}), 64'({e.x, e.y}));
        end
        last_blk = {blk_data, blk_x, blk_y};
        blk_cnt++;
      end
      if (done) seen_done++;
      prev_req_stall = rd_req && !rd_gnt;
      prev_addr      = rd_addr;
      prev_blk_stall = blk_valid && !blk_rtr;
      prev_blk       = {blk_data, blk_x, blk_y};
      prev_done      = done;
    end
  end

  // ---------------- test tasks ----------------
  task automatic check_zero(input string tag);
    check({tag, "_rd_req"}, 64'(rd_req), 64'd0);
    check({tag, "_rd_addr"}, 64'(rd_addr), 64'd0);
    check({tag, "_blk_valid"}, 64'(blk_valid), 64'd0);
    check({tag, "_blk_data"}, blk_data, 64'd0);
    check({tag, "_blk_xy"}, 64'({blk_x, blk_y}), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  task automatic start_job(input logic [31:0] base, input int w, input int h);
    push_job(base, w, h);
    blk_cnt = 0;
    @(posedge sclk);
    #1;
    src_base = base;
    width    = 11'(w);
    height   = 11'(h);
    start    = 1'b1;
    @(posedge sclk);
    #1;
    start    = 1'b0;
    src_base = $urandom;
    width    = 11'(4 * $urandom_range(256, 1));
    height   = 11'(4 * $urandom_range(256, 1));
    check("first_req", 64'({busy, rd_req, rd_addr}), 64'({2'b11, base}));
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (seen_done < exp_done && k < budget) begin
      @(negedge sclk);
      k++;
    end
    if (seen_done < exp_done) begin
      fail({tag, "_timeout"}, $sformatf("no done within %0d cycles", budget));
      seen_done = exp_done;
    end
    check({tag, "_req_drained"}, 64'(exp_req.size()), 64'd0);
    check({tag, "_blk_drained"}, 64'(exp_blk.size()), 64'd0);
    exp_req.delete();
    exp_blk.delete();
    @(negedge sclk);
    check({tag, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_blk_valid(input string tag);
    int k;
    k = 0;
    while (!blk_valid && k < 200) begin
      @(negedge sclk);
      k++;
    end
    if (!blk_valid) fail({tag, "_blk_timeout"}, "blk_valid never rose");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int w;
    int h;
    logic [31:0] base;
    logic [63:0] exp_const;

    repeat (3) @(negedge sclk);
    check_zero("reset");
    @(posedge sclk);
    #1;
    rsrt = 1'b0;
    @(negedge sclk);

    // Two-block image, immediate grant and next-cycle data
    gnt_pct = 100; lat_max = 0; rtr_force = 1;
    start_job(32'h1000, 8, 4);
    wait_done("basic", 200);
    check("basic_done_once", 64'(seen_done), 64'd1);
    check("basic_last_xy", 64'(last_blk[15:0]), 64'h0100);

    // Grant withheld 3 cycles in REQ0, then output stalled 5 cycles in OUT
    gnt_pct = 0; rtr_force = 0;
    @(negedge sclk);
    start_job(32'h2000, 8, 4);
    repeat (3) @(negedge sclk);
    check("gnt_stall_req", 64'({rd_req, rd_addr}), 64'({1'b1, 32'h2000}));
    gnt_pct = 100;
    wait_blk_valid("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      check("stall_no_req", 64'(rd_req), 64'd0);
    end
    rtr_force = 1;
    wait_done("stall", 200);

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      w = 4 * $urandom_range(12, 1);
      h = 4 * $urandom_range(12, 1);
      base = (j == 3) ? 32'hFFFF_FF80 : ($urandom & 32'hFFFF_FFF8);
      gnt_pct = $urandom_range(100, 40);
      lat_max = $urandom_range(3, 0);
      rtr_force = -1;
      rtr_pct = $urandom_range(100, 30);
      spur_en = 1'b1;
      @(negedge sclk);
      start_job(base, w, h);
      repeat ($urandom_range(2, 1)) @(posedge sclk);
      #1;
      start = 1'b1;
      @(posedge sclk);
      #1;
      start = 1'b0;
      wait_done($sformatf("rand%0d", j), 30000);
    end
    spur_en = 1'b0; gnt_pct = 100; lat_max = 0; rtr_force = 1;

    // Widest row: 256 x 2 blocks
    @(negedge sclk);
    start_job(32'h0004_0000, 1024, 8);
    wait_done("wide", 5000);
    check("wide_blk_cnt", 64'(blk_cnt), 64'd512);
    check("wide_last_xy", 64'(last_blk[15:0]), 64'hFF01);
    check("wide_last_addr", 64'(last_req_addr), 64'h0004_0FFC);

    // Start presented during the done cycle must be ignored
    rtr_force = 0;
    @(negedge sclk);
    start_job(32'h3000, 4, 4);
    wait_blk_valid("dstart");
    rtr_force = 1;
    @(posedge sclk);
    #1;
    @(posedge sclk);
    #1;
    check("dstart_done", 64'(done), 64'd1);
    start = 1'b1;
    @(posedge sclk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge sclk);
      check("dstart_idle", 64'({busy, rd_req}), 64'd0);
    end
    wait_done("dstart", 10);

    // Byte order of stored words
    const_data = 1'b1;
`ifdef ETC_FETCH_BSWAP_EN
    exp_const = 64'h44332211_44332211;
`else
    exp_const = 64'h11223344_11223344;
`endif
    @(negedge sclk);
    start_job(32'h5000, 4, 4);
    wait_done("bswap", 200);
    check("bswap_word", last_blk[79:16], exp_const);
    const_data = 1'b0;

    // Reset while the second read of a block is outstanding, then a late return
    hold_en = 1'b1;
    hold_addr = 32'h6004;
    @(negedge sclk);
    start_job(32'h6000, 8, 4);
    begin
      int k;
      k = 0;
      while (!(pending && pend_addr == 32'h6004) && k < 100) begin
        @(negedge sclk);
        k++;
      end
      if (!(pending && pend_addr == 32'h6004)) fail("rst_wait1_timeout", "word1 read never accepted");
    end
    @(posedge sclk);
    #1;
    rsrt = 1'b1;
    #1;
    check_zero("rst_mid");
    exp_req.delete();
    exp_blk.delete();
    exp_done--;
    @(negedge sclk);
    hold_en = 1'b0;
    @(posedge sclk);
    #1;
    rsrt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge sclk);
      check_zero("rst_late");
    end

    // Recovery after reset
    start_job(32'h7000, 4, 8);
    wait_done("recover", 200);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/etc_block_fetcher.md
ETC_BLOCK_FETCHER -- requirements
Module: etc_block_fetcher

Interface
REQ-001 SHALL have port sclk, input, 1: single clock, all logic on rising edge.
REQ-002 SHALL have port rsrt, input, 1: reset, asynchronous, active-high.
REQ-003 SHALL have port start, input, 1: one-cycle pulse begins an image fetch; ignored while busy=1.
REQ-004 SHALL have port src_base, input, 32: byte address of block (0,0); sampled on accepted start.
REQ-005 SHALL have port width, input, 11: image width in pixels, multiple of 4, range 4..1024; sampled on accepted start.
REQ-006 SHALL have port height, input, 11: image height in pixels, multiple of 4, range 4..1024; sampled on accepted start.
REQ-007 SHALL have port rd_req, output, 1: read request valid.
REQ-008 SHALL have port rd_addr, output, 32: 32-bit word byte address of read request.
REQ-009 SHALL have port rd_gnt, input, 1: memory accepts request when rd_req=1 and rd_gnt=1.
REQ-010 SHALL have port rd_dvalid, input, 1: read data return strobe.
REQ-011 SHALL have port rd_data, input, 32: read return data.
REQ-012 SHALL have port blk_valid, output, 1: compressed block available.
REQ-013 SHALL have port blk_rtr, input, 1: downstream decoder ready to receive.
REQ-014 SHALL have port blk_data, output, 64: compressed ETC2 block, [63:32]=first word, [31:0]=second word.
REQ-015 SHALL have port blk_x, output, 8: block column of blk_data.
REQ-016 SHALL have port blk_y, output, 8: block row of blk_data.
REQ-017 SHALL have port busy, output, 1: high from accepted start until done.
REQ-018 SHALL have port done, output, 1: one-cycle pulse after last block transferred.

Function
REQ-019 SHALL compute bpr = width[10:2] and bpc = height[10:2] at start; traversal raster order, blk_x fastest.
REQ-020 SHALL form block address = src_base + ((blk_y*bpr + blk_x) << 3), word1 address = block address + 4, modulo 2^32.
REQ-021 SHALL implement FSM IDLE -> REQ0 -> WAIT0 -> REQ1 -> WAIT1 -> OUT -> (REQ0 | DONE) -> IDLE.
REQ-022 SHALL leave IDLE on start, asserting rd_req with word0 address in the next cycle.
REQ-023 SHALL hold rd_req and rd_addr stable in REQx until rd_gnt=1, then move to WAITx.
REQ-024 SHALL allow at most one outstanding read; rd_dvalid outside WAITx SHALL be ignored.
REQ-025 SHALL capture rd_data on rd_dvalid in WAIT0 into blk_data[63:32], WAIT1 into blk_data[31:0].
REQ-026 SHALL assert blk_valid in OUT only, holding blk_data/blk_x/blk_y stable until blk_valid=1 and blk_rtr=1 in same cycle.
REQ-027 SHALL, on transfer of a non-last block, advance blk_x (wrap to 0 at bpr-1 with blk_y+1) and enter REQ0 next cycle.
REQ-028 SHALL, on transfer of block (bpr-1, bpc-1), enter DONE: done=1 one cycle, busy=0 from next cycle, state IDLE.
REQ-029 SHALL treat start coincident with done, or in any non-IDLE state, as ignored.
REQ-030 SHALL drive rd_req=0 and blk_valid=0 outside REQx and OUT respectively.

Reset
REQ-031 SHALL on rsrt=1 immediately force state IDLE, rd_req=0, rd_addr=0, blk_valid=0, blk_data=0, blk_x=0, blk_y=0, busy=0, done=0.
REQ-032 SHALL abandon any in-flight read on reset mid-operation; late rd_dvalid after reset is ignored.

Configuration
REQ-033 SHALL, with macro ETC_FETCH_BSWAP_EN defined, byte-reverse each captured rd_data word (byte0<->byte3, byte1<->byte2) before storing.
REQ-034 SHALL, without ETC_FETCH_BSWAP_EN, store rd_data unchanged.

Verification
REQ-035 SHALL cover: width=8,height=4,src_base=0x1000, rd_gnt=1, data returned next cycle -> rd_addr sequence 0x1000,0x1004,0x1008,0x100C; blocks (0,0),(1,0); done once.
REQ-036 SHALL cover: blk_rtr=0 for 5 cycles in OUT -> blk_valid held, blk_data/blk_x/blk_y unchanged, no new rd_req.
REQ-037 SHALL cover: rd_gnt low 3 cycles in REQ0 -> rd_req and rd_addr constant, single request accepted.
REQ-038 SHALL cover: width=1024,height=8 -> 512 blocks, last blk_x=255, blk_y=1, last word addr src_base+0xFFC.
REQ-039 SHALL cover: rsrt during WAIT1 then rd_dvalid -> all outputs zero, state IDLE, no blk_valid.
REQ-040 SHALL cover: rd_data=0x11223344 with ETC_FETCH_BSWAP_EN -> word 0x44332211; without -> 0x11223344.
